// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute->writeback stage; registers ALU bundles, drives RF write port and flag load,
// splitting MUL/DIV dual results into two RF writes. Define FORWARD_EN to drive the fwd_* bypass.
module ex_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int FLAG_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_opcode,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result_0,
    input  logic [DATA_W-1:0] ex_result_1,
    input  logic              ex_alu_en,
    input  logic [FLAG_W-1:0] ex_next_flags,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_we,
    output logic [FLAG_W-1:0] flags_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);
    localparam logic [4:0] OP_LBL  = 5'd0,  OP_LBH  = 5'd1,  OP_MOV  = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_MUL  = 5'd5,  OP_DIV  = 5'd6,  OP_NOT  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_INC  = 5'd11;
    localparam logic [4:0] OP_RR   = 5'd13, OP_RL   = 5'd14;
    localparam logic [4:0] OP_SETB = 5'd15, OP_CLRB = 5'd16, OP_CPLB = 5'd17;

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t              state;
    logic                dual_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   res1_q;
    logic                is_rf;
    logic                is_dual;

    assign is_dual = ex_opcode inside {OP_MUL, OP_DIV};
    assign is_rf   = ex_opcode inside {OP_LBL, OP_LBH, OP_MOV, OP_ADD, OP_SUB, OP_NOT, OP_AND,
                                       OP_OR, OP_XOR, OP_INC, OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB};
    assign ex_ready = !(state == WR_LO && dual_q);

    // Outputs are registered so each state's drive values are ready at the start of its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dual_q    <= 1'b0;
            rd_q      <= '0;
            res1_q    <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            flag_we   <= 1'b0;
            flags_out <= '0;
        end else if (!ex_ready) begin
            state    <= WR_HI;
            rf_we    <= 1'b1;
            rf_waddr <= rd_q + {{(REG_AW-1){1'b0}}, 1'b1};
            rf_wdata <= res1_q;
            flag_we  <= 1'b0;
        end else if (ex_valid) begin
            state     <= WR_LO;
            dual_q    <= is_dual;
            rd_q      <= ex_rd;
            res1_q    <= ex_result_1;
            rf_we     <= is_rf | is_dual;
            rf_waddr  <= ex_rd;
            rf_wdata  <= ex_result_0;
            flag_we   <= ex_alu_en;
            flags_out <= ex_next_flags;
        end else begin
            state   <= IDLE;
            rf_we   <= 1'b0;
            flag_we <= 1'b0;
        end
    end

`ifdef FORWARD_EN
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: randomized scoreboard bench for ex_wb_stage; expected RF/flag writes are
// queued with the cycle they must appear in and checked by an independent monitor.
module tb_ex_wb_stage;
    localparam int LBL = 0, LBH = 1, MOV = 2, ADD = 3, MUL = 5, DIV = 6, XOR = 10, CMP = 12;

    typedef struct {int c; logic [2:0] a; logic [15:0] d;} wr_t;
    typedef struct {int c; logic [15:0] f;} fl_t;

    logic        clk = 0, reset = 1, ex_valid = 0, ex_ready, ex_alu_en = 0;
    logic [4:0]  ex_opcode = 0;
    logic [2:0]  ex_rd = 0, rf_waddr, fwd_addr;
    logic [15:0] ex_result_0 = 0, ex_result_1 = 0, ex_next_flags = 0;
    logic [15:0] rf_wdata, flags_out, fwd_data;
    logic        rf_we, flag_we, fwd_valid;

    int tests = 0, fails = 0, cyc = 0, stall_cyc = -1;
    wr_t wq[$];
    fl_t fq[$];

    ex_wb_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_result_0(ex_result_0),
        .ex_result_1(ex_result_1), .ex_alu_en(ex_alu_en), .ex_next_flags(ex_next_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flag_we(flag_we),
        .flags_out(flags_out), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what each accepted instruction must eventually write, and when.
    task automatic model(int op, logic [2:0] rd, logic [15:0] r0, logic [15:0] r1, logic en, logic [15:0] fl);
        bit writes = (op inside {0, 1, 2, 3, 4, 7, 8, 9, 10, 11, 13, 14, 15, 16, 17});
        bit dual = (op == MUL || op == DIV);
        if (writes || dual) wq.push_back('{cyc + 1, rd, r0});
        if (dual) begin
            wq.push_back('{cyc + 2, 3'((int'(rd) + 1) % 8), r1});
            stall_cyc = cyc + 1;
        end
        if (en) fq.push_back('{cyc + 1, fl});
    endtask

    task automatic send(int op, logic [2:0] rd, logic [15:0] r0, logic [15:0] r1, logic en, logic [15:0] fl);
        bit done = 0;
        ex_valid = 1; ex_opcode = 5'(op); ex_rd = rd; ex_result_0 = r0; ex_result_1 = r1;
        ex_alu_en = en; ex_next_flags = fl;
        for (int t = 0; t < 4 && !done; t++) begin
            chk("ex_ready", 32'(ex_ready), 32'(cyc != stall_cyc));
            if (ex_ready === 1'b1) begin
                model(op, rd, r0, r1, en, fl);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
        ex_valid = 0;
    endtask

    task automatic idle(int n);
        ex_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_flag_we", 32'(flag_we), 0);
        chk("rst_ready", 32'(ex_ready), 1);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", 32'(rf_wdata), 0);
        chk("rst_flags", 32'(flags_out), 0);
        chk("rst_fwd", {fwd_valid, 13'd0, fwd_addr, fwd_data}, 0);
    endtask

    // Monitor: compares what the DUT presents each cycle against the scoreboard head.
    always begin
        bit ew, ef;
        @(posedge clk);
        #2;
        while (wq.size() > 0 && wq[0].c < cyc) void'(wq.pop_front());
        while (fq.size() > 0 && fq[0].c < cyc) void'(fq.pop_front());
        ew = wq.size() > 0 && wq[0].c == cyc;
        ef = fq.size() > 0 && fq[0].c == cyc;
        chk("rf_we", 32'(rf_we), 32'(ew));
        chk("flag_we", 32'(flag_we), 32'(ef));
        if (ew) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(wq[0].a));
            chk("rf_wdata", 32'(rf_wdata), 32'(wq[0].d));
        end
        if (ef) chk("flags_out", 32'(flags_out), 32'(fq[0].f));
`ifdef FORWARD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(ew));
        if (ew) chk("fwd_bypass", {13'd0, fwd_addr, fwd_data}, {13'd0, wq[0].a, wq[0].d});
`else
        chk("fwd_zero", {fwd_valid, 13'd0, fwd_addr, fwd_data}, 0);
`endif
        if (ew) void'(wq.pop_front());
        if (ef) void'(fq.pop_front());
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 0;
        @(negedge clk);
        send(ADD, 3, 16'h1234, 16'h0, 1, 16'h0080);
        chk("add_ready", 32'(ex_ready), 1);
        idle(1);
        send(MUL, 7, 16'h5678, 16'h0012, 1, 16'h0001);
        idle(3);
        send(MOV, 1, 16'h1111, 16'h0, 0, 16'h0);
        send(LBH, 2, 16'h2222, 16'h0, 0, 16'h0);
        send(XOR, 4, 16'h4444, 16'h0, 1, 16'h0004);
        idle(2);
        send(CMP, 6, 16'hdead, 16'h0, 1, 16'h0008);
        send(LBL, 5, 16'h00aa, 16'h0, 0, 16'hffff);
        send(DIV, 2, 16'hffff, 16'h0033, 1, 16'h0040);
        send(DIV, 7, 16'h0101, 16'h0202, 0, 16'h0);
        send(ADD, 5, 16'hbeef, 16'h0, 0, 16'h0);
        idle(3);
        // Reset in the middle of a MUL: the pending hi write must never appear.
        send(MUL, 4, 16'haaaa, 16'hbbbb, 1, 16'h0002);
        reset = 1;
        wq.delete();
        fq.delete();
        stall_cyc = -1;
        ex_valid = 1; ex_opcode = 5'(ADD); ex_rd = 1; ex_result_0 = 16'h7777;
        repeat (2) @(negedge clk);
        ex_valid = 0;
        check_reset_state();
        reset = 0;
        idle(4);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            else send(($urandom_range(3) == 0) ? ($urandom_range(1) ? MUL : DIV) : int'($urandom_range(31)),
                      3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
        end
        idle(4);
        chk("rf_queue_drained", 32'(wq.size()), 0);
        chk("flag_queue_drained", 32'(fq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
